// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM stage of the 5-stage pipeline. Issues loads/stores on a
//               valid/ready data-memory bus, aligns and extends load data and
//               registers the MEM/WB flow. Holds upstream via mem_stall while
//               a bus transaction is outstanding.
//               Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned
//               H/W accesses are flagged instead of issued).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    output logic            mem_stall,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [3:0]      dmem_req_be,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    output logic            out_valid,
    output logic            out_reg_write,
    output logic            out_misalign,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_wb_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_is_b;
    logic              w_is_h;
    logic              w_is_mem;
    logic              w_trap;
    logic              w_go;
    logic              w_complete;
    logic              w_load_done;
    logic              w_req_valid;
    logic [1:0]        w_addr_lo;
    logic [1:0]        w_lane_off;
    logic [7:0]        w_rsp_byte;
    logic [15:0]       w_rsp_half;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_wdata;
    logic [3:0]        w_be;

    logic              r_out_valid;
    logic              r_out_reg_write;
    logic              r_out_misalign;
    logic [4:0]        r_out_rd;
    logic [XLEN-1:0]   r_out_wb_data;

    // Size 2'b11 is not a legal encoding; it falls through to word handling.
    assign w_is_b    = (in_funct3[1:0] == c_SZ_B);
    assign w_is_h    = (in_funct3[1:0] == c_SZ_H);
    assign w_addr_lo = in_alu_result[1:0];
    assign w_is_mem  = in_valid & (in_is_load | in_is_store);

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = (w_is_h & w_addr_lo[0]) |
                          (~w_is_b & ~w_is_h & (w_addr_lo != 2'b00));
    assign w_trap       = w_is_mem & w_misaligned;
`else
    // Without trapping, misaligned low bits are simply dropped in lane_off.
    assign w_trap = 1'b0;
`endif

    assign w_go = w_is_mem & ~w_trap;

    // Byte lane of the access: halves round down to an even lane, words to 0.
    assign w_lane_off = w_is_b ? w_addr_lo :
                        w_is_h ? {w_addr_lo[1], 1'b0} : 2'b00;

    // Store lane steering: replicate narrow data across the word, enable lanes.
    always_comb begin
        w_wdata = in_store_data;
        w_be    = 4'b1111;
        if (w_is_b) begin
            w_wdata = {4{in_store_data[7:0]}};
            w_be    = 4'b0001 << w_lane_off;
        end else if (w_is_h) begin
            w_wdata = {2{in_store_data[15:0]}};
            w_be    = 4'b0011 << w_lane_off;
        end
    end

    assign dmem_req_valid = w_req_valid;
    assign dmem_req_we    = in_is_store;
    assign dmem_req_addr  = {in_alu_result[XLEN-1:2], 2'b00};
    assign dmem_req_wdata = w_wdata;
    assign dmem_req_be    = w_be;

    // Pick the addressed byte out of the returned word.
    always_comb begin
        w_rsp_byte = dmem_rsp_rdata[7:0];
        case (w_lane_off)
            2'd1:    w_rsp_byte = dmem_rsp_rdata[15:8];
            2'd2:    w_rsp_byte = dmem_rsp_rdata[23:16];
            2'd3:    w_rsp_byte = dmem_rsp_rdata[31:24];
            default: w_rsp_byte = dmem_rsp_rdata[7:0];
        endcase
    end

    assign w_rsp_half = w_lane_off[1] ? dmem_rsp_rdata[31:16] : dmem_rsp_rdata[15:0];

    // Sign- or zero-extend the selected load lane; funct3[2] marks unsigned.
    always_comb begin
        w_load_data = dmem_rsp_rdata;
        if (w_is_b) begin
            w_load_data = {{24{~in_funct3[2] & w_rsp_byte[7]}}, w_rsp_byte};
        end else if (w_is_h) begin
            w_load_data = {{16{~in_funct3[2] & w_rsp_half[15]}}, w_rsp_half};
        end
    end

    // Bus FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, request valid and completion; stall whenever not completing.
    always_comb begin
        w_state_next = r_state;
        w_req_valid  = 1'b0;
        w_complete   = 1'b0;
        w_load_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_req_valid = 1'b1;
                    if (dmem_req_ready) begin
                        w_state_next = in_is_load ? ST_RESP : ST_IDLE;
                        w_complete   = ~in_is_load;
                    end else begin
                        w_state_next = ST_REQ;
                    end
                end else begin
                    w_complete = 1'b1;
                end
            end
            ST_REQ: begin
                w_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    w_state_next = in_is_load ? ST_RESP : ST_IDLE;
                    w_complete   = ~in_is_load;
                end
            end
            ST_RESP: begin
                if (dmem_rsp_valid) begin
                    w_state_next = ST_IDLE;
                    w_complete   = 1'b1;
                    w_load_done  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_stall = ~w_complete;

    // MEM/WB register: capture the finished instruction, otherwise a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid     <= 1'b0;
            r_out_reg_write <= 1'b0;
            r_out_misalign  <= 1'b0;
            r_out_rd        <= 5'd0;
            r_out_wb_data   <= '0;
        end else if (w_complete) begin
            r_out_valid     <= in_valid;
            r_out_reg_write <= in_valid & in_reg_write & ~in_is_store & ~w_trap;
            r_out_misalign  <= w_trap;
            r_out_rd        <= in_rd;
            r_out_wb_data   <= w_load_done ? w_load_data : in_alu_result;
        end else begin
            r_out_valid     <= 1'b0;
            r_out_reg_write <= 1'b0;
            r_out_misalign  <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_reg_write = r_out_reg_write;
    assign out_misalign  = r_out_misalign;
    assign out_rd        = r_out_rd;
    assign out_wb_data   = r_out_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage: directed scenarios
//               followed by randomized ops against a behavioural model of the
//               MEM stage and a bus model with random ready/response delays.
//               Honours MEM_MISALIGN_TRAP_EN when computing expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_is_load, in_is_store, in_reg_write;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result, in_store_data;
    logic [4:0]  in_rd;
    logic        mem_stall;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        out_valid, out_reg_write, out_misalign;
    logic [4:0]  out_rd;
    logic [31:0] out_wb_data;

    int n_vec = 0;
    int n_err = 0;

    mem_access_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_funct3      (in_funct3),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .mem_stall      (mem_stall),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_req_be    (dmem_req_be),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .out_valid      (out_valid),
        .out_reg_write  (out_reg_write),
        .out_misalign   (out_misalign),
        .out_rd         (out_rd),
        .out_wb_data    (out_wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store. Called just after a rising edge.
    task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] rd, input logic rw,
                          input int rdy_wait, input int rsp_wait,
                          input logic [31:0] rdata, input logic valid);
        int          nbytes, off, cyc, sa;
        bit          mem, trap, bus, accepted, done, fin;
        longint      v;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_wb;
        in_valid      = valid;
        in_is_load    = (kind == 1);
        in_is_store   = (kind == 2);
        in_funct3     = f3;
        in_alu_result = addr;
        in_store_data = sd;
        in_rd         = rd;
        in_reg_write  = rw;

        nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off    = int'(addr % 4) - (int'(addr % 4) % nbytes);
        mem    = valid && (kind != 0);
`ifdef MEM_MISALIGN_TRAP_EN
        trap   = mem && ((addr % nbytes) != 0);
`else
        trap   = 1'b0;
`endif
        bus    = mem && !trap;
        exp_be = 4'(((1 << nbytes) - 1) << off);
        exp_wd = (nbytes == 1) ? sd[7:0] * 32'h01010101 :
                 (nbytes == 2) ? sd[15:0] * 32'h00010001 : sd;
        v = longint'(rdata) >> (8 * off);
        if (nbytes < 4) begin
            v = v & ((64'd1 << (8 * nbytes)) - 1);
            if (!f3[2] && v >= (64'd1 << (8 * nbytes - 1))) v = v - (64'd1 << (8 * nbytes));
        end
        exp_wb = (kind == 1 && bus) ? 32'(v) : addr;

        accepted = 0; done = 0; cyc = 0; sa = 0;
        while (!done) begin
            @(negedge clk);
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b0;
            dmem_rsp_rdata = $urandom;
            if (bus && !accepted) begin
                dmem_req_ready = (cyc >= rdy_wait);
                dmem_rsp_valid = 1'($urandom % 2);
            end else if (bus) begin
                dmem_rsp_valid = (sa >= rsp_wait);
                if (dmem_rsp_valid) dmem_rsp_rdata = rdata;
            end else begin
                dmem_rsp_valid = 1'($urandom % 2);
            end
            #1;
            fin = !bus || (kind == 2 && !accepted && dmem_req_ready) || (accepted && dmem_rsp_valid);
            check("req_valid", 32'(dmem_req_valid), 32'(bus && !accepted));
            if (bus && !accepted) begin
                check("req_addr", dmem_req_addr, addr & 32'hFFFF_FFFC);
                check("req_we", 32'(dmem_req_we), 32'(kind == 2));
                check("req_be", 32'(dmem_req_be), 32'(exp_be));
                if (kind == 2) check("req_wdata", dmem_req_wdata, exp_wd);
            end
            check("mem_stall", 32'(mem_stall), 32'(!fin));
            @(posedge clk);
            #1;
            if (accepted) sa++;
            if (bus && !accepted && dmem_req_ready) begin
                accepted = 1;
                sa = 0;
            end
            check("out_valid", 32'(out_valid), 32'(fin && valid));
            check("out_reg_write", 32'(out_reg_write), 32'(fin && valid && rw && kind != 2 && !trap));
            if (fin) begin
                check("out_misalign", 32'(out_misalign), 32'(trap));
                if (valid) begin
                    check("out_rd", 32'(out_rd), 32'(rd));
                    check("out_wb_data", out_wb_data, exp_wb);
                end
                done = 1;
            end
            cyc++;
            check("cycle_budget", 32'(cyc > 60), 32'd0);
            if (cyc > 60) done = 1;
        end
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        int kind;
        logic [2:0] f3;
        ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
        ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

        reset = 1'b1;
        in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
        in_alu_result = 0; in_store_data = 0; in_rd = 0; in_reg_write = 0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_reg_write", 32'(out_reg_write), 32'd0);
        check("rst_out_misalign", 32'(out_misalign), 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_wb_data", out_wb_data, 32'd0);
        check("rst_mem_stall", 32'(mem_stall), 32'd0);
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ALU op passes through in one cycle
        run_op(0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0, 1'b1);
        // SB at 0x103, immediately accepted
        run_op(2, 3'b000, 32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0, 0, 0, 32'h0, 1'b1);
        // LB / LBU at 0x102, response the cycle after acceptance
        run_op(1, 3'b000, 32'h0000_0102, 32'h0, 5'd3, 1'b1, 0, 0, 32'h0080_0000, 1'b1);
        run_op(1, 3'b100, 32'h0000_0102, 32'h0, 5'd3, 1'b1, 0, 0, 32'h0080_0000, 1'b1);
        // SW held off for 3 cycles
        run_op(2, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 5'd0, 1'b0, 3, 0, 32'h0, 1'b1);
        // LH at odd address: trapped or low half, depending on build
        run_op(1, 3'b001, 32'h0000_0101, 32'h0, 5'd7, 1'b1, 0, 0, 32'h1234_BEEF, 1'b1);
        // LHU, slow ready and slow response
        run_op(1, 3'b101, 32'h0000_0342, 32'h0, 5'd9, 1'b1, 2, 3, 32'h8765_4321, 1'b1);

        // Reset while a load waits for its response; late response ignored
        in_valid = 1; in_is_load = 1; in_is_store = 0; in_funct3 = 3'b010;
        in_alu_result = 32'h0000_0200; in_rd = 5'd4; in_reg_write = 1;
        @(negedge clk);
        dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
        #1;
        check("rstmid_req_valid", 32'(dmem_req_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        check("rstmid_resp_stall", 32'(mem_stall), 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_out_wb", out_wb_data, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hFFFF_FFFF;
        #1;
        check("rstmid_stall", 32'(mem_stall), 32'd0);
        check("rstmid_req_idle", 32'(dmem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rstmid_late_rsp_valid", 32'(out_valid), 32'd0);
        check("rstmid_late_rsp_wb", out_wb_data, 32'h0000_0200);
        run_op(0, 3'b000, 32'h0000_0055, 32'h0, 5'd6, 1'b1, 0, 0, 32'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 2));
            f3   = (kind == 2) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            run_op(kind, f3, $urandom, $urandom, 5'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom, ($urandom % 8) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
